// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the EX-stage branch resolver: opcodes, branch funct3 codes,
// PC mux selects, and the branch-condition helpers.
package branch_resolve_unit_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] PCSEL_SEQ     = 3'b000;
  localparam logic [2:0] PCSEL_BR      = 3'b001;
  localparam logic [2:0] PCSEL_JAL     = 3'b010;
  localparam logic [2:0] PCSEL_JALR    = 3'b011;
  localparam logic [2:0] PCSEL_RECOVER = 3'b100;

  typedef struct packed {
    logic [2:0] pc_sel;
    logic       flush;
    logic [2:0] rf_sel;
  } redirect_t;

  function automatic logic br_legal(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

  function automatic logic br_cond(input logic [2:0] f3, input logic z, input logic n,
                                   input logic ltu);
    case (f3)
      F3_BEQ:  return z;
      F3_BNE:  return !z;
      F3_BLT:  return n;
      F3_BGE:  return !n;
      F3_BLTU: return ltu;
      F3_BGEU: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Branch history table of 2-bit saturating counters: combinational read,
// write applied at the clock edge, synchronous active-low reset to weakly not-taken.
module bht_2bit #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [DEPTH-1:0][1:0] cnt;

  // No write bypass: a same-index read sees the value from before this edge.
  assign rd_cnt = cnt[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= {DEPTH{2'b01}};
    end else if (wr_en) begin
      if (wr_taken && cnt[wr_idx] != 2'b11)
        cnt[wr_idx] <= cnt[wr_idx] + 2'd1;
      else if (!wr_taken && cnt[wr_idx] != 2'b00)
        cnt[wr_idx] <= cnt[wr_idx] - 2'd1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: compares outcome to the IF-time BHT prediction, drives PC/RF
// selects and flush, and suppresses redirects for FLUSH_STAGES cycles after each flush.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_DEPTH    = 64,
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_pred_taken,
  input  logic             Z,
  input  logic             N,
  input  logic             LTU,
  input  logic [2:0]       RF_sel_in,
  output logic [2:0]       RF_sel_out,
  output logic [2:0]       PC_sel,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int SH_W  = 2;

  logic [SH_W-1:0] shadow;
  logic [1:0]      rd_cnt;
  logic            act, br_taken, bht_we, mispredict;
  redirect_t       res;

  logic unused_bits;
  assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2],
                         ex_pc[1:0], rd_cnt[0]};

  bht_2bit #(.DEPTH(BHT_DEPTH), .IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_cnt   (rd_cnt),
    .wr_en    (bht_we),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (br_taken)
  );

  assign if_pred_taken = rd_cnt[1];

  always_comb begin
    act        = rst && ex_valid && (shadow == '0);
    br_taken   = br_cond(ex_funct3, Z, N, LTU);
    res        = '{pc_sel: PCSEL_SEQ, flush: 1'b0, rf_sel: 3'b000};
    bht_we     = 1'b0;
    mispredict = 1'b0;
    if (act) begin
      case (ex_opcode)
        OP_BRANCH: begin
          // Illegal funct3 resolves as a silent not-taken: no training, no redirect.
          if (br_legal(ex_funct3)) begin
            bht_we     = 1'b1;
            mispredict = br_taken != ex_pred_taken;
            if (br_taken && !ex_pred_taken)
              res = '{pc_sel: PCSEL_BR, flush: 1'b1, rf_sel: 3'b000};
            else if (!br_taken && ex_pred_taken)
              res = '{pc_sel: PCSEL_RECOVER, flush: 1'b1, rf_sel: 3'b000};
          end
        end
        OP_JAL:  res = '{pc_sel: PCSEL_JAL, flush: 1'b1, rf_sel: RF_sel_in};
        OP_JALR: begin
          if (ex_funct3 == 3'b000)
            res = '{pc_sel: PCSEL_JALR, flush: 1'b1, rf_sel: RF_sel_in};
        end
        default: res.rf_sel = RF_sel_in;
      endcase
    end
  end

  assign PC_sel     = res.pc_sel;
  assign flush      = res.flush;
  assign RF_sel_out = res.rf_sel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow         <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (flush)
        shadow <= SH_W'(FLUSH_STAGES);
      else if (shadow != '0)
        shadow <= shadow - SH_W'(1);
      if (mispredict && mispredict_cnt != '1)
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit against a behavioural model of
// counters, shadow window and branch rules.
module tb_branch_resolve_unit;

  localparam int XLEN = 32, DEPTH = 64, FS = 2, CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  if_pc, ex_pc;
  logic             if_pred_taken;
  logic             ex_valid, ex_pred_taken, Z, N, LTU;
  logic [6:0]       ex_opcode;
  logic [2:0]       ex_funct3, RF_sel_in, RF_sel_out, PC_sel;
  logic             flush;
  logic [CNT_W-1:0] mispredict_cnt;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .FLUSH_STAGES(FS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_pred_taken(ex_pred_taken), .Z(Z), .N(N), .LTU(LTU), .RF_sel_in(RF_sel_in),
    .RF_sel_out(RF_sel_out), .PC_sel(PC_sel), .flush(flush), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int bht [DEPTH];
  int m_shadow = 0;
  int m_cnt    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  // Expected outputs for the current inputs and model state.
  task automatic model_eval(output int pcs, output int fl, output int rfo,
                            output int train, output int tk, output int mis);
    bit active;
    pcs = 0; fl = 0; rfo = 0; train = 0; tk = 0; mis = 0;
    active = (rst === 1'b1) && (ex_valid === 1'b1) && (m_shadow == 0);
    if (!active) return;
    if (ex_opcode == 7'b1100011) begin
      case (ex_funct3)
        3'd0: tk = (Z == 1);
        3'd1: tk = (Z == 0);
        3'd4: tk = (N == 1);
        3'd5: tk = (N == 0);
        3'd6: tk = (LTU == 1);
        3'd7: tk = (LTU == 0);
        default: tk = 0;
      endcase
      if (ex_funct3 != 3'd2 && ex_funct3 != 3'd3) begin
        train = 1;
        if (tk == 1 && ex_pred_taken == 0) begin pcs = 1; fl = 1; mis = 1; end
        if (tk == 0 && ex_pred_taken == 1) begin pcs = 4; fl = 1; mis = 1; end
      end
    end else if (ex_opcode == 7'b1101111) begin
      pcs = 2; fl = 1; rfo = RF_sel_in;
    end else if (ex_opcode == 7'b1100111) begin
      if (ex_funct3 == 3'd0) begin pcs = 3; fl = 1; rfo = RF_sel_in; end
    end else begin
      rfo = RF_sel_in;
    end
  endtask

  initial for (int i = 0; i < DEPTH; i++) bht[i] = 1;

  // Model state advance at each active edge, from pre-edge state and inputs.
  always @(posedge clk) begin
    int pcs, fl, rfo, train, tk, mis, ix;
    model_eval(pcs, fl, rfo, train, tk, mis);
    if (rst !== 1'b1) begin
      for (int i = 0; i < DEPTH; i++) bht[i] = 1;
      m_shadow = 0;
      m_cnt    = 0;
    end else begin
      if (train == 1) begin
        ix = idx_of(ex_pc);
        if (tk == 1) bht[ix] = (bht[ix] < 3) ? bht[ix] + 1 : 3;
        else         bht[ix] = (bht[ix] > 0) ? bht[ix] - 1 : 0;
      end
      if (fl == 1)            m_shadow = FS;
      else if (m_shadow > 0)  m_shadow = m_shadow - 1;
      if (mis == 1 && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    int pcs, fl, rfo, train, tk, mis;
    model_eval(pcs, fl, rfo, train, tk, mis);
    chk("pc_sel", int'(PC_sel), pcs);
    chk("flush", int'(flush), fl);
    chk("rf_sel_out", int'(RF_sel_out), rfo);
    chk("mispredict_cnt", int'(mispredict_cnt), m_cnt);
    chk("if_pred_taken", int'(if_pred_taken), (bht[idx_of(if_pc)] >= 2) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input bit v, input logic [6:0] op, input logic [2:0] f3,
                        input int ix, input bit pred, input bit z, input bit n, input bit ltu,
                        input logic [2:0] rf);
    ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_pc = XLEN'(ix * 4);
    ex_pred_taken = pred; Z = z; N = n; LTU = ltu; RF_sel_in = rf;
  endtask

  task automatic idle(input int n);
    ex_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  initial begin
    logic [6:0] ops [8];
    ops[0] = BR; ops[1] = BR; ops[2] = BR; ops[3] = BR;
    ops[4] = JAL; ops[5] = JALR; ops[6] = 7'b0110011; ops[7] = 7'b0010111;

    rst = 1'b0; if_pc = '0;
    set_ex(1, JAL, 3'd0, 3, 0, 0, 0, 0, 3'b001);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_pc_sel", int'(PC_sel), 0);
      chk("rst_flush", int'(flush), 0);
      tick();
    end
    rst = 1'b1; ex_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if_pc = XLEN'(i * 4);
      #1 chk("rst_bht", int'(if_pred_taken), 0);
    end
    chk("rst_cnt", int'(mispredict_cnt), 0);
    tick();

    // Mispredicted taken BEQ, then two shadowed JALs, then a live JAL
    set_ex(1, BR, 3'd0, 16, 0, 1, 0, 0, 3'b111);
    @(negedge clk);
    chk("beq_pc_sel", int'(PC_sel), 1);
    chk("beq_flush", int'(flush), 1);
    tick();
    chk("beq_cnt", int'(mispredict_cnt), 1);
    set_ex(1, JAL, 3'd0, 17, 0, 0, 0, 0, 3'b001);
    for (int i = 0; i < FS; i++) begin
      @(negedge clk);
      chk("shadow_pc_sel", int'(PC_sel), 0);
      chk("shadow_flush", int'(flush), 0);
      tick();
    end
    @(negedge clk);
    chk("post_shadow_pc_sel", int'(PC_sel), 2);
    chk("post_shadow_flush", int'(flush), 1);
    tick();
    idle(FS + 1);

    // Training at idx 7: 01 -> 10 -> 11, then down to 00 and saturate
    if_pc = XLEN'(7 * 4);
    set_ex(1, BR, 3'd4, 7, 0, 0, 1, 0, 3'b000);
    tick(); idle(FS + 1);
    set_ex(1, BR, 3'd4, 7, 0, 0, 1, 0, 3'b000);
    tick(); idle(FS + 1);
    chk("train_strong_taken", int'(if_pred_taken), 1);
    set_ex(1, BR, 3'd4, 7, 0, 0, 0, 0, 3'b000);
    tick();
    chk("train_11_to_10", int'(if_pred_taken), 1);
    tick();
    chk("train_10_to_01", int'(if_pred_taken), 0);
    tick(); tick();
    set_ex(1, BR, 3'd4, 7, 0, 0, 1, 0, 3'b000);
    tick();
    chk("train_sat_at_00", int'(if_pred_taken), 0);
    idle(FS + 1);

    // Unsigned flag selection
    set_ex(1, BR, 3'd7, 9, 1, 0, 0, 1, 3'b000);
    @(negedge clk);
    chk("bgeu_pc_sel", int'(PC_sel), 4);
    chk("bgeu_flush", int'(flush), 1);
    tick(); idle(FS + 1);
    set_ex(1, BR, 3'd6, 9, 1, 0, 0, 1, 3'b000);
    @(negedge clk);
    chk("bltu_pc_sel", int'(PC_sel), 0);
    chk("bltu_flush", int'(flush), 0);
    tick();

    // JALR funct3 handling
    set_ex(1, JALR, 3'd1, 10, 0, 0, 0, 0, 3'b101);
    @(negedge clk);
    chk("jalr_bad_pc_sel", int'(PC_sel), 0);
    chk("jalr_bad_rf", int'(RF_sel_out), 0);
    tick();
    set_ex(1, JALR, 3'd0, 10, 0, 0, 0, 0, 3'b010);
    @(negedge clk);
    chk("jalr_pc_sel", int'(PC_sel), 3);
    chk("jalr_flush", int'(flush), 1);
    chk("jalr_rf", int'(RF_sel_out), 2);
    tick(); idle(FS + 1);

    // Same-index read during write, then reset while shadowed
    if_pc = XLEN'(5 * 4);
    set_ex(1, BR, 3'd0, 5, 0, 1, 0, 0, 3'b000);
    @(negedge clk);
    chk("same_cycle_old", int'(if_pred_taken), 0);
    tick();
    ex_valid = 1'b0;
    chk("same_cycle_new", int'(if_pred_taken), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_ex(1, JAL, 3'd0, 6, 0, 0, 0, 0, 3'b011);
    @(negedge clk);
    chk("rst_shadow_pc_sel", int'(PC_sel), 2);
    chk("rst_shadow_flush", int'(flush), 1);
    tick();

    // Randomized phase, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      set_ex(($urandom_range(0, 9) < 8), ops[$urandom_range(0, 7)], 3'($urandom),
             int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 3'($urandom));
      if_pc = XLEN'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
